conv_layer_sequencer: RTL

Sequencing controller for one convolution layer feature-map engine (the bank of parallel Conv2D3x3 instances sharing one `data_in` bus and one `valid_in`). It walks an IMG_SIZE x IMG_SIZE input map in raster order and issues reads to the feature-map memory. It generates the engine's `valid_in` aligned with returned memory data. It also tags which pushes complete a full 3x3 window, so downstream accumulation knows when to sample, and signals completion of the layer pass.

---
 rtl/conv_layer_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/conv_layer_sequencer.sv
// Raster-order read sequencer for a 3x3 conv engine: issues reads, tags pushes, flags complete windows.
// Reads issue in the cycle the position is current; push/window tags follow one cycle later, aligned with memory data.
// i_hold freezes issue only; reads already issued still return. SEQ_PAD_EN selects same-padding mode.
module conv_layer_sequencer #(
    parameter int IMG_SIZE    = 104,
    parameter int ADDR_WIDTH  = 14,
    parameter int COORD_WIDTH = 7
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_hold,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  o_mem_rd_addr,
    output logic                   o_conv_valid_in,
    output logic                   o_pad_zero,
    output logic                   o_win_valid,
    output logic [COORD_WIDTH-1:0] o_win_row,
    output logic [COORD_WIDTH-1:0] o_win_col
);

`ifdef SEQ_PAD_EN
    localparam int LAST_POS = IMG_SIZE + 1;
`else
    localparam int LAST_POS = IMG_SIZE - 1;
`endif
    localparam logic [COORD_WIDTH-1:0] C_LAST = COORD_WIDTH'(LAST_POS);
    localparam logic [COORD_WIDTH-1:0] C_TWO  = COORD_WIDTH'(2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [COORD_WIDTH-1:0] r_row;
    logic [COORD_WIDTH-1:0] r_col;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_conv_vld;
    logic                   r_pad;
    logic                   r_win_vld;
    logic [COORD_WIDTH-1:0] r_win_row;
    logic [COORD_WIDTH-1:0] r_win_col;

    logic w_issue;
    logic w_col_wrap;
    logic w_last;
    logic w_pad;
    logic w_read;
    logic w_win;

    assign w_issue    = (r_state == S_RUN) && !i_hold;
    assign w_col_wrap = (r_col == C_LAST);
    assign w_last     = w_col_wrap && (r_row == C_LAST);
`ifdef SEQ_PAD_EN
    // Border ring of the padded map is pushed as zeros and never touches memory.
    assign w_pad = (r_row == '0) || (r_row == C_LAST) || (r_col == '0) || (r_col == C_LAST);
`else
    assign w_pad = 1'b0;
`endif
    assign w_read = w_issue && !w_pad;
    assign w_win  = (r_row >= C_TWO) && (r_col >= C_TWO);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_issue && w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address walks as a plain counter: interior positions arrive in raster order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || r_state != S_RUN) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if (w_issue) begin
            if (w_last) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
            if (w_last) begin
                r_addr <= '0;
            end else if (w_read) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_conv_vld <= 1'b0;
            r_pad      <= 1'b0;
            r_win_vld  <= 1'b0;
            r_win_row  <= '0;
            r_win_col  <= '0;
        end else begin
            r_conv_vld <= w_issue;
            r_pad      <= w_issue && w_pad;
            r_win_vld  <= w_issue && w_win;
            if (w_issue && w_win) begin
                r_win_row <= r_row - C_TWO;
                r_win_col <= r_col - C_TWO;
            end
        end
    end

    assign o_busy          = (r_state != S_IDLE);
    assign o_done          = (r_state == S_DONE);
    assign o_mem_rd_en     = w_read;
    assign o_mem_rd_addr   = r_addr;
    assign o_conv_valid_in = r_conv_vld;
    assign o_pad_zero      = r_pad;
    assign o_win_valid     = r_win_vld;
    assign o_win_row       = r_win_row;
    assign o_win_col       = r_win_col;

endmodule
